// File: rtl/lcd_byte_writer_pkg.sv
// Shared definitions for the HD44780-style 4-bit LCD byte writer: state
// encoding, default timing constants and small helpers.
package lcd_byte_writer_pkg;

  localparam int CNT_W = 20;

  localparam int DEF_SETUP      = 2;
  localparam int DEF_PULSE      = 12;
  localparam int DEF_HOLD       = 1;
  localparam int DEF_NIBBLE_GAP = 50;
  localparam int DEF_BYTE_GAP   = 2000;
  localparam int DEF_LONG_GAP   = 82000;
  localparam int DEF_POWERUP    = 750000;
  localparam int DEF_INIT1      = 205000;
  localparam int DEF_INIT2      = 5000;

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_SETUP,
    INIT_PULSE,
    INIT_HOLD,
    INIT_GAP,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    NIB_GAP,
    BYTE_GAP
  } state_t;

  // A state lasting n cycles is entered with the counter loaded to n-1.
  function automatic count_t cycles(input int n);
    return count_t'(n - 1);
  endfunction

  // Clear Display / Return Home / its alias need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Byte request handshake between a host and the LCD byte writer.
interface lcd_byte_writer_if;

  logic [7:0] data;
  logic       register_select;
  logic       valid;
  logic       ready;
  logic       done;

  modport master (
    output data, register_select, valid,
    input  ready, done
  );

  modport slave (
    input  data, register_select, valid,
    output ready, done
  );

endinterface

// File: rtl/lcd_delay_counter.sv
// Shared 20-bit down-counter timing every FSM state; zero marks the last
// cycle of the current state.
module lcd_delay_counter
  import lcd_byte_writer_pkg::*;
#(
  parameter count_t RESET_VALUE = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  count_t load_value,
  output logic   zero
);

  count_t count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - count_t'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// Writes bytes to a 4-bit LCD as two E-strobed nibbles, after running the
// power-up wait and the 3,3,3,2 init nibble sequence.
module lcd_byte_writer
  import lcd_byte_writer_pkg::*;
#(
  parameter int P_SETUP      = DEF_SETUP,
  parameter int P_PULSE      = DEF_PULSE,
  parameter int P_HOLD       = DEF_HOLD,
  parameter int P_NIBBLE_GAP = DEF_NIBBLE_GAP,
  parameter int P_BYTE_GAP   = DEF_BYTE_GAP,
  parameter int P_LONG_GAP   = DEF_LONG_GAP,
  parameter int P_POWERUP    = DEF_POWERUP,
  parameter int P_INIT1      = DEF_INIT1,
  parameter int P_INIT2      = DEF_INIT2
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_byte_writer_if.slave   host,
  output logic [3:0]         lcd,
  output logic               enable,
  output logic               register_select,
  output logic               read_write
);

  state_t     state, next_state;
  logic       load;
  count_t     load_value;
  logic       zero;
  logic       accept;
  logic       init_next;
  logic [7:0] byte_q;
  logic       rs_q;
  logic       lower_q;
  logic [1:0] init_idx;
  logic       in_init, in_byte;

  lcd_delay_counter #(
    .RESET_VALUE (cycles(P_POWERUP))
  ) u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (load_value),
    .zero       (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PWR_WAIT;
    end else begin
      state <= next_state;
    end
  end

  // Each state exits on the counter's last cycle and preloads the next duration.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_value = '0;
    accept     = 1'b0;
    init_next  = 1'b0;
    unique case (state)
      PWR_WAIT: if (zero) begin
        next_state = INIT_SETUP;
        load       = 1'b1;
        load_value = cycles(P_SETUP);
      end
      INIT_SETUP: if (zero) begin
        next_state = INIT_PULSE;
        load       = 1'b1;
        load_value = cycles(P_PULSE);
      end
      INIT_PULSE: if (zero) begin
        next_state = INIT_HOLD;
        load       = 1'b1;
        load_value = cycles(P_HOLD);
      end
      INIT_HOLD: if (zero) begin
        next_state = INIT_GAP;
        load       = 1'b1;
        unique case (init_idx)
          2'd0:    load_value = cycles(P_INIT1);
          2'd1:    load_value = cycles(P_INIT2);
          default: load_value = cycles(P_BYTE_GAP);
        endcase
      end
      INIT_GAP: if (zero) begin
        if (init_idx == 2'd3) begin
          next_state = IDLE;
        end else begin
          next_state = INIT_SETUP;
          load       = 1'b1;
          load_value = cycles(P_SETUP);
          init_next  = 1'b1;
        end
      end
      IDLE: if (host.valid) begin
        next_state = SETUP;
        load       = 1'b1;
        load_value = cycles(P_SETUP);
        accept     = 1'b1;
      end
      SETUP: if (zero) begin
        next_state = PULSE;
        load       = 1'b1;
        load_value = cycles(P_PULSE);
      end
      PULSE: if (zero) begin
        next_state = HOLD;
        load       = 1'b1;
        load_value = cycles(P_HOLD);
      end
      HOLD: if (zero) begin
        load = 1'b1;
        if (lower_q) begin
          next_state = BYTE_GAP;
          load_value = is_long_cmd(rs_q, byte_q) ? cycles(P_LONG_GAP)
                                                 : cycles(P_BYTE_GAP);
        end else begin
          next_state = NIB_GAP;
          load_value = cycles(P_NIBBLE_GAP);
        end
      end
      NIB_GAP: if (zero) begin
        next_state = SETUP;
        load       = 1'b1;
        load_value = cycles(P_SETUP);
      end
      BYTE_GAP: if (zero) begin
        next_state = IDLE;
      end
      default: next_state = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
      lower_q  <= 1'b0;
      init_idx <= 2'd0;
    end else begin
      if (accept) begin
        byte_q  <= host.data;
        rs_q    <= host.register_select;
        lower_q <= 1'b0;
      end
      if (state == NIB_GAP && zero) begin
        lower_q <= 1'b1;
      end
      if (init_next) begin
        init_idx <= init_idx + 2'd1;
      end
    end
  end

  assign in_init = state inside {INIT_SETUP, INIT_PULSE, INIT_HOLD, INIT_GAP};
  assign in_byte = state inside {SETUP, PULSE, HOLD, NIB_GAP, BYTE_GAP};

  // Pin values depend only on registered state, so reset clears them at once.
  always_comb begin
    lcd             = 4'h0;
    register_select = 1'b0;
    if (in_init) begin
      lcd = (init_idx == 2'd3) ? 4'h2 : 4'h3;
    end else if (in_byte) begin
      lcd             = lower_q ? byte_q[3:0] : byte_q[7:4];
      register_select = rs_q;
    end
  end

  assign enable     = (state == PULSE) || (state == INIT_PULSE);
  assign read_write = 1'b0;
  assign host.ready = (state == IDLE);
  assign host.done  = (state == BYTE_GAP) && zero;

endmodule
